memory_bank_sweeper: RTL and testbench
======================================

Name: memory_bank_sweeper

Overview:
- Initiator (master) for the banked memory wrapper interface: drives shared addr/wr_rd, packed per-bank wdata and per-bank valid; consumes per-bank ready and rdata.
- Runs a write pass over every address in all banks in parallel, then a read-back pass that compares each bank against the expected pattern.
- Reports pass/fail, per-bank fail mask, error count and a handshake timeout.
- Sits between the test/config logic and the NUM_MEMS-bank memory array.

Parameters:
- NUM_MEMS, 8, number of banks (one valid/ready pair each)
- DEPTH, 64, words per bank
- WIDTH, 8, data bits per bank
- ADDR_SIZE, 6, address width (DEPTH = 2**ADDR_SIZE)
- TIMEOUT, 255, max cycles to wait at one address for all readies

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a sweep when idle
- seed  in  WIDTH  pattern seed, sampled on accepted start
- addr  out  ADDR_SIZE  shared address to all banks
- wr_rd  out  1  1 = write, 0 = read
- wdata  out  NUM_MEMS*WIDTH  bank b occupies bits [(b+1)*WIDTH-1 : b*WIDTH]
- valid  out  NUM_MEMS  per-bank request
- rdata  in  NUM_MEMS*WIDTH  per-bank read data, same packing as wdata
- ready  in  NUM_MEMS  per-bank completion
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  last sweep had no errors and no timeout
- fail_mask  out  NUM_MEMS  banks with at least one miscompare
- err_count  out  16  total miscompares, saturating at 16'hFFFF
- timeout  out  1  last sweep aborted on handshake timeout

Behaviour:
- Reset (rst=0, async):
  - All outputs 0: addr, wr_rd, wdata, valid, busy, done, pass, fail_mask, err_count, timeout.
  - FSM to IDLE; internal pending mask and timeout counter cleared.
- Transfer rule: a bank transfer completes in the cycle valid[b]&ready[b] is high. For reads, rdata for bank b is sampled in that same cycle.
- Pattern: expected data for bank b at address a = (seed + a + b) mod 2**WIDTH.
- FSM states and transitions:
  - IDLE: start=1 latches seed; clears fail_mask, err_count, pass, timeout; sets busy=1, addr=0, wr_rd=1, valid=all ones, wdata=pattern(0). Go to WRITE.
  - WRITE:
    - Each bank whose ready is seen has its valid bit dropped the next cycle. A bank still pending keeps valid high with addr/wdata stable.
    - When the last pending bank completes: if addr≠DEPTH-1, next cycle addr+1, valid=all ones, new wdata. If addr=DEPTH-1, next cycle addr=0, wr_rd=0, valid=all ones; go to READ.
  - READ:
    - Same per-bank handshake. On each bank completion, compare rdata slice to pattern.
    - On mismatch: set fail_mask[b] and increment err_count. Multiple banks mismatching in one cycle add their popcount, saturating at 16'hFFFF.
    - At addr=DEPTH-1 with all banks complete, go to FINISH.
  - FINISH (one cycle): valid=0, busy=0, done=1, pass=(err_count==0 && !timeout). Go to IDLE.
- Minimum of one cycle of valid per address. Full-speed sweep = DEPTH cycles per pass when ready is returned combinationally.
- Timeout:
  - Counter resets on every address advance; increments each cycle while any valid is high.
  - On reaching TIMEOUT: set timeout=1, drop all valid, go to FINISH (pass=0). fail_mask/err_count keep their values.
- Corner cases:
  - ready[b] while valid[b]=0 is ignored.
  - start while busy is ignored.
  - start in the FINISH cycle is ignored.
  - Status outputs hold until the next accepted start.
  - Reset mid-sweep aborts immediately to reset values; no done pulse.
- wdata slices of banks no longer pending hold their value; don't-care to the memory.

Test Plan:
1. Ideal memory (ready=valid, correct readback), seed=8'h00 → 128 cycles of valid activity; done pulses once; pass=1, err_count=0, fail_mask=8'h00; bank 3 at addr 5 written 8'h08.
2. seed=8'hFE, addr=63, bank 7 → wdata byte 7 = 8'h44 (wrap mod 256); read pass expects same value.
3. Bank 2 ready delayed 3 cycles at every address → valid[2] held 4 cycles with stable addr/wdata; other banks drop valid after 1 cycle; pass=1.
4. Bank 5 returns rdata^8'h01 at addr 10 and addr 20 → fail_mask=8'h20, err_count=2, pass=0.
5. Bank 0 never asserts ready during write at addr 7, TIMEOUT=255 → after 255 cycles valid=0, timeout=1, done pulse, pass=0, busy=0.
6. Assert rst=0 mid-read at addr 30 → all outputs 0 asynchronously. start pulse during busy → ignored. A new start after done clears status and reruns the sweep.

Source files
------------

// File: rtl/memory_bank_sweeper.sv
// Initiator for a banked memory array: writes a seed-derived pattern to every address of every
// bank in parallel, reads it all back, and reports per-bank miscompares and handshake timeouts.
module memory_bank_sweeper #(
  parameter int unsigned NUM_MEMS  = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          seed,
  output logic [ADDR_SIZE-1:0]      addr,
  output logic                      wr_rd,
  output logic [NUM_MEMS*WIDTH-1:0] wdata,
  output logic [NUM_MEMS-1:0]       valid,
  input  logic [NUM_MEMS*WIDTH-1:0] rdata,
  input  logic [NUM_MEMS-1:0]       ready,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [NUM_MEMS-1:0]       fail_mask,
  output logic [15:0]               err_count,
  output logic                      timeout
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StFinish} state_e;

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          seed_q, seed_d;
  logic [ADDR_SIZE-1:0]      addr_q, addr_d;
  logic                      wr_rd_q, wr_rd_d;
  logic [NUM_MEMS*WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_MEMS-1:0]       valid_q, valid_d;
  logic [TW-1:0]             tcnt_q, tcnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pass_q, pass_d;
  logic [NUM_MEMS-1:0]       fail_q, fail_d;
  logic [15:0]               err_q, err_d;
  logic                      timeout_q, timeout_d;

  logic [NUM_MEMS-1:0]       xfer;
  logic [NUM_MEMS-1:0]       pend;
  logic [NUM_MEMS-1:0]       mism;
  logic [16:0]               err_sum;

  function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0]     s,
                                               input logic [ADDR_SIZE-1:0] a,
                                               input int unsigned          b);
    return s + WIDTH'(a) + WIDTH'(b);
  endfunction

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    addr_d    = addr_q;
    wr_rd_d   = wr_rd_q;
    wdata_d   = wdata_q;
    valid_d   = valid_q;
    tcnt_d    = tcnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    fail_d    = fail_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    xfer      = valid_q & ready;
    pend      = valid_q & ~ready;
    mism      = '0;
    err_sum   = {1'b0, err_q};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          seed_d    = seed;
          fail_d    = '0;
          err_d     = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          addr_d    = '0;
          wr_rd_d   = 1'b1;
          valid_d   = '1;
          tcnt_d    = '0;
          for (int unsigned b = 0; b < NUM_MEMS; b++) begin
            wdata_d[b*WIDTH +: WIDTH] = pattern(seed, '0, b);
          end
          state_d   = StWrite;
        end
      end

      StWrite, StRead: begin
        if (state_q == StRead) begin
          for (int unsigned b = 0; b < NUM_MEMS; b++) begin
            if (xfer[b] && (rdata[b*WIDTH +: WIDTH] != pattern(seed_q, addr_q, b))) begin
              mism[b] = 1'b1;
            end
          end
          for (int unsigned b = 0; b < NUM_MEMS; b++) begin
            err_sum = err_sum + 17'(mism[b]);
          end
          fail_d = fail_q | mism;
          err_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end

        if (pend == '0) begin
          // Every bank has completed at this address.
          tcnt_d = '0;
          if (addr_q != LAST) begin
            addr_d  = addr_q + 1'b1;
            valid_d = '1;
            if (state_q == StWrite) begin
              for (int unsigned b = 0; b < NUM_MEMS; b++) begin
                wdata_d[b*WIDTH +: WIDTH] = pattern(seed_q, addr_q + 1'b1, b);
              end
            end
          end else if (state_q == StWrite) begin
            addr_d  = '0;
            wr_rd_d = 1'b0;
            valid_d = '1;
            state_d = StRead;
          end else begin
            valid_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 16'h0000) && !timeout_q;
            state_d = StFinish;
          end
        end else if (tcnt_q == TLIM) begin
          timeout_d = 1'b1;
          valid_d   = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          state_d   = StFinish;
        end else begin
          valid_d = pend;
          tcnt_d  = tcnt_q + 1'b1;
        end
      end

      StFinish: begin
        // start is deliberately not sampled here.
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      seed_q    <= '0;
      addr_q    <= '0;
      wr_rd_q   <= 1'b0;
      wdata_q   <= '0;
      valid_q   <= '0;
      tcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      addr_q    <= addr_d;
      wr_rd_q   <= wr_rd_d;
      wdata_q   <= wdata_d;
      valid_q   <= valid_d;
      tcnt_q    <= tcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign addr      = addr_q;
  assign wr_rd     = wr_rd_q;
  assign wdata     = wdata_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;
  assign err_count = err_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_memory_bank_sweeper.sv
// Bench for memory_bank_sweeper: a banked memory model with per-bank ready delay, read
// corruption and a stuck bank, checked against pattern arithmetic and sweep-level counts.
`timescale 1ns/1ps
module tb_memory_bank_sweeper;

  localparam int NM = 8;
  localparam int DP = 64;
  localparam int WD = 8;
  localparam int AS = 6;
  localparam int TO = 255;
  localparam int STUCK_ADDR = 7;
  localparam int BOUND = 5000;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [WD-1:0]  seed;
  logic [AS-1:0]  addr;
  logic           wr_rd;
  logic [NM*WD-1:0] wdata;
  logic [NM-1:0]  valid;
  logic [NM*WD-1:0] rdata;
  logic [NM-1:0]  ready;
  logic           busy;
  logic           done;
  logic           pass;
  logic [NM-1:0]  fail_mask;
  logic [15:0]    err_count;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_bank_sweeper #(
    .NUM_MEMS (NM),
    .DEPTH    (DP),
    .WIDTH    (WD),
    .ADDR_SIZE(AS),
    .TIMEOUT  (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed     (seed),
    .addr     (addr),
    .wr_rd    (wr_rd),
    .wdata    (wdata),
    .valid    (valid),
    .rdata    (rdata),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_mask(fail_mask),
    .err_count(err_count),
    .timeout  (timeout)
  );

  // Memory model
  logic [WD-1:0] mem   [NM][DP];
  logic [WD-1:0] cmask [NM][DP];
  int  dly  [NM];
  int  hold [NM];
  bit  stuck_en;
  bit  noise;

  always_comb begin
    ready = '0;
    for (int b = 0; b < NM; b++) begin
      if (valid[b]) begin
        ready[b] = (hold[b] >= dly[b]) &&
                   !(stuck_en && b == 0 && wr_rd && int'(addr) == STUCK_ADDR);
      end else begin
        ready[b] = noise;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int b = 0; b < NM; b++) begin
      rdata[b*WD +: WD] = mem[b][addr] ^ cmask[b][addr];
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NM; b++) hold[b] <= 0;
    end else begin
      for (int b = 0; b < NM; b++) begin
        if (valid[b] && !ready[b]) hold[b] <= hold[b] + 1;
        else hold[b] <= 0;
      end
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < NM; b++) begin
      if (valid[b] && ready[b] && wr_rd) mem[b][addr] <= wdata[b*WD +: WD];
    end
  end

  // Sweep monitor: cumulative counters sampled on the falling edge.
  int act_cyc = 0;
  int done_cnt = 0;
  int stab_err = 0;
  int stuck_cyc = 0;
  int vcyc [NM];
  int rdx  [NM];
  logic [NM-1:0]    pv, pr;
  logic [AS-1:0]    pa;
  logic [NM*WD-1:0] pw;

  always @(negedge clk) begin
    if (!rst) begin
      pv <= '0;
      pr <= '0;
    end else begin
      if (valid != '0) act_cyc <= act_cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (valid[0] && wr_rd && int'(addr) == STUCK_ADDR) stuck_cyc <= stuck_cyc + 1;
      for (int b = 0; b < NM; b++) begin
        if (valid[b]) vcyc[b] <= vcyc[b] + 1;
        if (valid[b] && ready[b] && !wr_rd) rdx[b] <= rdx[b] + 1;
        // A pending bank must keep its request and its address/data unchanged.
        if (pv[b] && !pr[b] && !timeout &&
            (!valid[b] || addr != pa || wdata[b*WD +: WD] != pw[b*WD +: WD])) begin
          stab_err <= stab_err + 1;
        end
      end
      pv <= valid;
      pr <= ready;
      pa <= addr;
      pw <= wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < NM; b++) begin
      dly[b] = 0;
      for (int a = 0; a < DP; a++) cmask[b][a] = '0;
    end
    stuck_en = 1'b0;
    noise    = 1'b0;
  endtask

  task automatic run_sweep(input logic [WD-1:0] s, input int glitch_at, input bit exp_to);
    int base_act, base_done, base_stab, base_stuck;
    int base_v [NM];
    int base_r [NM];
    int n, exp_err, maxd, bad;
    logic [NM-1:0] exp_mask;
    logic [WD-1:0] e;

    exp_err  = 0;
    exp_mask = '0;
    maxd     = 0;
    for (int b = 0; b < NM; b++) begin
      if (dly[b] > maxd) maxd = dly[b];
      for (int a = 0; a < DP; a++) begin
        if (!exp_to && cmask[b][a] != '0) begin
          exp_err++;
          exp_mask[b] = 1'b1;
        end
      end
    end

    @(negedge clk);
    base_act   = act_cyc;
    base_done  = done_cnt;
    base_stab  = stab_err;
    base_stuck = stuck_cyc;
    for (int b = 0; b < NM; b++) begin
      base_v[b] = vcyc[b];
      base_r[b] = rdx[b];
    end
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", 64'(busy), 64'd1);
    check_eq("start_clr_status", 64'({pass, timeout, fail_mask, err_count}), 64'd0);

    n = 0;
    while (!done && n < BOUND) begin
      @(negedge clk);
      n++;
      if (n == glitch_at) begin
        start = 1'b1;
        seed  = ~s;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("done_seen", 64'(done), 64'd1);
    check_eq("end_pass", 64'(pass), 64'((exp_err == 0) && !exp_to));
    check_eq("end_timeout", 64'(timeout), 64'(exp_to));
    check_eq("end_err_count", 64'(err_count), 64'(exp_err));
    check_eq("end_fail_mask", 64'(fail_mask), 64'(exp_mask));
    check_eq("end_idle_bus", 64'({busy, valid}), 64'd0);

    if (exp_to) begin
      check_eq("stuck_valid_cycles", 64'(stuck_cyc - base_stuck), 64'(TO));
    end else begin
      bad = 0;
      for (int b = 0; b < NM; b++) begin
        for (int a = 0; a < DP; a++) begin
          e = WD'(int'(s) + a + b);
          if (mem[b][a] !== e) bad++;
        end
      end
      check_eq("mem_image", 64'(bad), 64'd0);
      check_eq("act_cycles", 64'(act_cyc - base_act), 64'(2 * DP * (maxd + 1)));
      check_eq("hold_stable", 64'(stab_err - base_stab), 64'd0);
      for (int b = 0; b < NM; b++) begin
        check_eq($sformatf("valid_cycles_b%0d", b), 64'(vcyc[b] - base_v[b]),
                 64'(2 * DP * (dly[b] + 1)));
        check_eq($sformatf("read_xfers_b%0d", b), 64'(rdx[b] - base_r[b]), 64'(DP));
      end
    end

    // start during the done cycle must not launch a sweep.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("finish_start_ignored", 64'({busy, done}), 64'd0);
    check_eq("done_pulses", 64'(done_cnt - base_done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, k, base_done;
    rst   = 1'b1;
    start = 1'b0;
    seed  = '0;
    clear_model();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_ctrl", 64'({addr, wr_rd, valid, busy, done, pass, fail_mask, err_count,
                                timeout}), 64'd0);
    check_eq("reset_wdata", wdata, 64'd0);
    rst = 1'b1;

    // Ideal memory
    run_sweep(8'h00, -1, 1'b0);
    check_eq("b3_a5_seed00", 64'(mem[3][5]), 64'h08);

    // Pattern wrap
    run_sweep(8'hFE, -1, 1'b0);
    check_eq("b7_a63_seedfe", 64'(mem[7][63]), 64'h44);

    // Slow bank 2, stray readies on idle banks
    dly[2] = 3;
    noise  = 1'b1;
    run_sweep(8'h5C, -1, 1'b0);
    clear_model();

    // Corrupted reads on bank 5
    cmask[5][10] = 8'h01;
    cmask[5][20] = 8'h01;
    run_sweep(8'h21, -1, 1'b0);
    clear_model();

    // Bank 0 never completes write at addr 7
    stuck_en = 1'b1;
    run_sweep(8'h90, -1, 1'b1);
    clear_model();

    // Randomized delays, stray readies and corruption
    for (int it = 0; it < 4; it++) begin
      clear_model();
      noise = bit'($urandom_range(0, 1));
      for (int b = 0; b < NM; b++) dly[b] = int'($urandom_range(0, 2));
      k = int'($urandom_range(0, 4));
      for (int j = 0; j < k; j++) begin
        cmask[$urandom_range(0, NM - 1)][$urandom_range(0, DP - 1)] = WD'($urandom_range(1, 255));
      end
      run_sweep(WD'($urandom), -1, 1'b0);
    end
    clear_model();

    // Reset in the middle of the read pass
    @(negedge clk);
    seed  = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(busy && !wr_rd && addr == 6'd30) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_read_a30", 64'(busy && !wr_rd && addr == 6'd30), 64'd1);
    base_done = done_cnt;
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_ctrl", 64'({addr, wr_rd, valid, busy, done, pass, fail_mask, err_count,
                                 timeout}), 64'd0);
    check_eq("midrst_wdata", wdata, 64'd0);
    repeat (3) @(negedge clk);
    check_eq("midrst_no_done", 64'(done_cnt - base_done), 64'd0);
    rst = 1'b1;

    // start while busy is ignored, then a fresh sweep after done
    run_sweep(8'h77, 40, 1'b0);
    run_sweep(8'hA5, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
